// File: rtl/ram8_clr.sv
// 8-word register file with one-hot write decode, 8-to-1 combinational read mux,
// and a sequenced clear that zeroes one word per cycle while busy is high.
module ram8_clr #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_in,
  input  logic             i_load,
  input  logic [2:0]       i_address,
  input  logic             i_clear,
  output logic [WIDTH-1:0] o_out,
  output logic             o_busy
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_cnt;
  logic [WIDTH-1:0] r_mem [8];
  logic [7:0]       w_wr_sel;
  logic [7:0]       w_clr_sel;

  always_comb begin
    w_state_nxt = r_state;
    w_wr_sel    = 8'd0;
    w_clr_sel   = 8'd0;
    case (r_state)
      ST_IDLE: begin
        // Load still lands on the same edge that starts a sweep.
        if (i_load)  w_wr_sel    = 8'd1 << i_address;
        if (i_clear) w_state_nxt = ST_SWEEP;
      end
      ST_SWEEP: begin
        w_clr_sel = 8'd1 << r_cnt;
        if (r_cnt == 3'd7) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 3'd0;
      for (int k = 0; k < 8; k++) r_mem[k] <= '0;
    end else begin
      r_state <= w_state_nxt;
      // Natural 3-bit wrap returns cnt to 0 exactly on the exit edge.
      r_cnt   <= (r_state == ST_SWEEP) ? r_cnt + 3'd1 : 3'd0;
      for (int k = 0; k < 8; k++) begin
        if (w_wr_sel[k])       r_mem[k] <= i_in;
        else if (w_clr_sel[k]) r_mem[k] <= '0;
      end
    end
  end

  assign o_out  = r_mem[i_address];
  assign o_busy = (r_state == ST_SWEEP);

endmodule

// File: tb/tb_ram8_clr.sv
// Bench for ram8_clr: a behavioural memory model feeds a scoreboard queue of
// expected read values that are popped and compared against the DUT read port.
module tb_ram8_clr;

  logic        clk;
  logic        reset;
  logic [15:0] din;
  logic        load;
  logic [2:0]  address;
  logic        clear;
  logic [15:0] dout;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [15:0] m [8];
  logic        m_busy;
  logic [2:0]  m_cnt;
  logic [15:0] sb [$];

  ram8_clr #(.WIDTH(16)) dut (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_in      (din),
    .i_load    (load),
    .i_address (address),
    .i_clear   (clear),
    .o_out     (dout),
    .o_busy    (busy)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock edge with the given inputs; the model advances as the spec describes.
  task automatic step(input logic rst, input logic ld, input logic [2:0] a,
                      input logic [15:0] d, input logic clr);
    reset = rst; load = ld; address = a; din = d; clear = clr;
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 8; k++) m[k] = 16'h0;
      m_busy = 1'b0;
      m_cnt  = 3'd0;
    end else if (!m_busy) begin
      if (ld) m[a] = d;
      if (clr) begin
        m_busy = 1'b1;
        m_cnt  = 3'd0;
      end
    end else begin
      m[m_cnt] = 16'h0;
      if (m_cnt == 3'd7) m_busy = 1'b0;
      m_cnt = m_cnt + 3'd1;
    end
    #1;
    reset = 1'b0; load = 1'b0; clear = 1'b0;
    check("busy", {31'd0, busy}, {31'd0, m_busy});
  endtask

  task automatic rd(input logic [2:0] a, input string tag);
    sb.push_back(m[a]);
    address = a;
    #2;
    check(tag, {16'd0, dout}, {16'd0, sb.pop_front()});
  endtask

  task automatic rd_all(input string tag);
    for (int k = 0; k < 8; k++) rd(k[2:0], tag);
  endtask

  task automatic fill();
    for (int k = 0; k < 8; k++) step(1'b0, 1'b1, k[2:0], 16'h1111 * 16'(k + 1), 1'b0);
  endtask

  initial begin
    reset = 1'b0; load = 1'b0; address = 3'd0; din = 16'h0; clear = 1'b0;
    m_busy = 1'b0; m_cnt = 3'd0;
    for (int k = 0; k < 8; k++) m[k] = 16'hxxxx;

    // 1: reset clears everything
    step(1'b1, 1'b0, 3'd0, 16'h0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      address = k[2:0];
      #2;
      check("reset_word", {16'd0, dout}, 32'd0);
    end
    check("reset_busy", {31'd0, busy}, 32'd0);

    // 2: distinct value per word, no cross-writes
    fill();
    rd_all("fill_read");
    address = 3'd5;
    #2;
    check("fill_w5_const", {16'd0, dout}, 32'h6666);

    // 3: load=0 does not write
    step(1'b0, 1'b1, 3'd3, 16'hBEEF, 1'b0);
    step(1'b0, 1'b0, 3'd3, 16'hFFFF, 1'b0);
    address = 3'd3;
    #2;
    check("noload_hold", {16'd0, dout}, 32'hBEEF);
    rd_all("noload_read");

    // 4: full sweep, one word per edge
    fill();
    step(1'b0, 1'b0, 3'd0, 16'h0, 1'b1);
    check("sweep_start_busy", {31'd0, busy}, 32'd1);
    for (int e = 1; e <= 8; e++) begin
      step(1'b0, 1'b0, 3'd0, 16'h0, 1'b0);
      rd_all("sweep_read");
    end
    check("sweep_end_busy", {31'd0, busy}, 32'd0);

    // 5: load and re-clear ignored during sweep
    fill();
    step(1'b0, 1'b0, 3'd0, 16'h0, 1'b1);          // N
    step(1'b0, 1'b0, 3'd0, 16'h0, 1'b0);          // N+1
    step(1'b0, 1'b1, 3'd7, 16'h1234, 1'b0);       // N+2 load dropped
    address = 3'd7;
    #2;
    check("drop_w7_pre", {16'd0, dout}, 32'h8888);
    step(1'b0, 1'b0, 3'd0, 16'h0, 1'b1);          // N+3 clear ignored
    for (int e = 4; e <= 8; e++) step(1'b0, 1'b0, 3'd0, 16'h0, 1'b0);
    check("reclear_busy_low", {31'd0, busy}, 32'd0);
    address = 3'd7;
    #2;
    check("drop_w7_zero", {16'd0, dout}, 32'h0);
    step(1'b0, 1'b0, 3'd0, 16'h0, 1'b0);
    check("no_restart", {31'd0, busy}, 32'd0);
    rd_all("post_sweep_read");

    // 6: reset aborts a sweep, then a write succeeds
    fill();
    step(1'b0, 1'b0, 3'd0, 16'h0, 1'b1);          // N
    for (int e = 1; e <= 3; e++) step(1'b0, 1'b0, 3'd0, 16'h0, 1'b0);
    address = 3'd6;
    #2;
    check("abort_w6_pre", {16'd0, dout}, 32'h7777);
    step(1'b1, 1'b0, 3'd0, 16'h0, 1'b0);          // N+4 reset
    check("abort_busy", {31'd0, busy}, 32'd0);
    rd_all("abort_read");
    step(1'b0, 1'b1, 3'd5, 16'h00AA, 1'b0);
    address = 3'd5;
    #2;
    check("after_abort_w5", {16'd0, dout}, 32'h00AA);
    rd_all("after_abort_read");
    step(1'b0, 1'b0, 3'd0, 16'h0, 1'b0);
    check("after_abort_idle", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
